// File: rtl/aes_pkg.sv
// Shared AES constants: byte width, forward/inverse S-box tables and the
// SubBytes engine state encoding.
package aes_pkg;

  localparam int BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Derived from the forward table so the pair is an exact inverse by construction.
  function automatic logic [255:0][7:0] invert_sbox();
    logic [255:0][7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[SBOX_FWD[i]] = 8'(i);
    return r;
  endfunction

  localparam logic [255:0][7:0] SBOX_INV = invert_sbox();

endpackage

// File: rtl/sbox_lane.sv
// One combinational AES S-box lookup, forward or inverse; shared with the
// key-expansion SubWord path.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [BYTE-1:0] byte_i,
  input  logic            inv_i,
  output logic [BYTE-1:0] byte_o
);

  assign byte_o = inv_i ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes: substitutes LANES bytes of the working register
// per cycle, with valid/ready handshakes on input and output.
//
// state   | meaning
// IDLE    | waiting for a block, in_ready high
// RUN     | substituting beat cnt of the working register
// DONE    | result presented, out_valid high until out_ready
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BYTE   = 8,
  parameter int LENGTH = 128,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic              busy
);

  localparam int BEAT_W = BYTE * LANES;
  localparam int BEATS  = LENGTH / BEAT_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         mode_q, mode_d;
  logic [BEATS-1:0][BEAT_W-1:0] work_q, work_d;
  logic [BEATS-1:0][BEAT_W-1:0] work_upd;
  logic [BEAT_W-1:0]            beat_in, beat_out;

  // Beat select/write-back; a single-beat state needs no index at all.
  if (BEATS == 1) begin : g_single
    assign beat_in  = work_q[0];
    assign work_upd = beat_out;
  end else begin : g_multi
    assign beat_in = work_q[cnt_q];
    always_comb begin
      work_upd        = work_q;
      work_upd[cnt_q] = beat_out;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .byte_i (beat_in[BYTE*l +: BYTE]),
      .inv_i  (mode_q),
      .byte_o (beat_out[BYTE*l +: BYTE])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          mode_d  = in_inv;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        work_d = work_upd;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = work_q;

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Parametrised, multi-cycle AES SubBytes unit: it substitutes every byte of a LENGTH-bit state through either the forward or the inverse AES S-box. It uses LANES S-box lookups per cycle and moves data over a valid/ready handshake on both sides. It sits between the round-key adder and ShiftRows in the cipher datapath, and it also serves the key-expansion SubWord step with LENGTH=32.

## Interface
- BYTE, 8, byte width in bits (fixed by AES; only 8 is supported).
- LENGTH, 128, state width in bits; must be a multiple of BYTE*LANES.
- LANES, 4, S-box lookups per cycle; legal values 1, 2, 4, 8, 16.

Derived constant: BEATS = LENGTH/(BYTE*LANES).

- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data and in_inv are valid.
- in_ready  out  1  engine accepts a block.
- in_data  in  LENGTH  state; byte i = in_data[BYTE*i +: BYTE].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled on accept.
- out_valid  out  1  out_data holds the result.
- out_ready  in  1  consumer takes the result.
- out_data  out  LENGTH  substituted state, same byte ordering as in_data.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: beat counter cnt runs 0..BEATS-1.
  - DONE: out_valid=1.
- Accept: in_valid && in_ready in IDLE.
  - Load the working register with in_data.
  - Latch mode from in_inv.
  - cnt <= 0; go to RUN.
- RUN, each cycle:
  - Bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register are replaced by S(byte), or S⁻¹(byte) when mode=1.
  - Other bytes hold.
  - cnt increments.
  - When cnt==BEATS-1: go to DONE, cnt <= 0.
- DONE:
  - out_data = working register; holds stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid deasserts next cycle.
- in_inv, in_data and in_valid are ignored outside IDLE. Mode cannot change mid-block.
- The forward and inverse tables are the FIPS-197 S-box and its exact inverse. Every 8-bit input has a defined output; there is no default/zero fallback.
- Only one block is in flight. A new accept is possible only in the cycle after the DONE handshake.
- rst at any cycle, including mid-RUN and in DONE, has the same effect:
  - state <= IDLE, cnt <= 0, mode <= 0.
  - Working register <= 0, out_valid <= 0.
  - The partial block is discarded.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0. in_ready = (state==IDLE) && !rst, so it is 0 while rst is high and 1 in the first cycle after.
- Latency: accept in cycle T, then out_valid=1 in cycle T+BEATS+1. With defaults this is T+5 (BEATS=4).
- Throughput with out_ready held high: one block per BEATS+2 cycles.
- LANES=LENGTH/BYTE gives BEATS=1: RUN lasts one cycle and latency is 2.
- out_data is a register output; no combinational path from in_* to out_*.
- out_ready low in DONE: out_valid and out_data hold indefinitely.

## Structure
- Shared package aes_pkg holds:
  - BYTE.
  - Forward and inverse S-box constant arrays.
  - State enum (IDLE/RUN/DONE).
- Sub-module sbox_lane: combinational 8-bit lookup with inputs byte and inv, output byte. It is instantiated LANES times, and the key expansion reuses it.
- The engine holds the FSM, cnt (width clog2(BEATS), min 1), the working register, the mode bit, and a byte-select mux/demux driven by cnt.

## Test plan
- Forward, defaults, in_data=00112233445566778899aabbccddeeff, in_inv=0 -> out_data=638293c31bfc33f5c4eeacea4bc12816, out_valid exactly 5 cycles after accept.
- Inverse: in_data=638293c31bfc33f5c4eeacea4bc12816, in_inv=1 -> 00112233445566778899aabbccddeeff.
- Exhaustive per byte for LANES in {1,4,16}:
  - Every byte value 00..ff in each byte position, forward then inverse, returns the original value.
  - Spot checks: S(00)=63, S(53)=ed, S⁻¹(63)=00, S⁻¹(ed)=53.
- Backpressure: out_ready low for 10 cycles in DONE -> out_data stable, in_ready=0. Then out_ready pulse -> in_ready=1 next cycle; an immediate second block completes correctly.
- Reset mid-RUN: rst at cnt=2 -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1. A following block with all bytes 00, forward mode -> all bytes 63.
- in_inv toggled during RUN -> result uses the mode latched at accept.
